// File: rtl/tb04_pkg.sv
// Shared definitions for the miniTB04 sequencer and ALU: phase numbering,
// sequencer state encoding, opcodes and the PC update rule.
package tb04_pkg;

  // Phase presented to the ALU on `cycle`; one instruction walks 1,2,3,4,5,0.
  localparam logic [2:0] CYC_CLEAR  = 3'd1;
  localparam logic [2:0] CYC_FETCH  = 3'd2;
  localparam logic [2:0] CYC_WAIT   = 3'd3;
  localparam logic [2:0] CYC_DECODE = 3'd4;
  localparam logic [2:0] CYC_EXEC   = 3'd5;
  localparam logic [2:0] CYC_WB     = 3'd0;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } seq_state_t;

  // Opcodes carried in instruction bits [7:4]; decoded by the ALU.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;

  // Writeback PC: taken jump loads the ALU target, otherwise increment with wrap.
  function automatic logic [3:0] next_pc(input logic       take,
                                         input logic [3:0] target,
                                         input logic [3:0] cur_pc);
    return take ? target : cur_pc + 4'd1;
  endfunction

endpackage

// File: rtl/tb04_fetch_timer.sv
// Counts clocks spent waiting for ROM data; flags the clock on which the
// wait budget runs out so the sequencer can abandon the fetch.
module tb04_fetch_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  logic [7:0] count;

  // Terminal count: this would be the ACK_TIMEOUT-th clock without an ack.
  assign expired = count_en && (count == 8'(ACK_TIMEOUT - 1));

  // Wait counter, restarted whenever the wait ends or the budget is spent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/tb04_sequencer.sv
// miniTB04 instruction sequencer: phase generator, program counter,
// ROM fetch handshake, instruction register and run/step/halt control.
module tb04_sequencer
  import tb04_pkg::*;
#(
  parameter logic [3:0]  RESET_PC    = 4'd0,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       clear_fault,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  input  logic       jump,
  input  logic [3:0] data,
  output logic [2:0] cycle,
  output logic [3:0] pc,
  output logic       rom_req,
  output logic [3:0] rom_addr,
  output logic [3:0] command,
  output logic [3:0] immediate,
  output logic       wb_strobe,
  output logic       retire,
  output logic       running,
  output logic       fault
);

  seq_state_t state;
  logic [7:0] ir;
  logic       timer_count;
  logic       timer_clear;
  logic       timed_out;

  assign timer_count = (state != ST_HALT) && (cycle == CYC_WAIT) && !rom_ack;
  assign timer_clear = !timer_count;

  tb04_fetch_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_fetch_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (timer_count),
    .clear    (timer_clear),
    .expired  (timed_out)
  );

  assign command   = ir[7:4];
  assign immediate = ir[3:0];
  assign rom_addr  = pc;
  assign wb_strobe = (cycle == CYC_WB);

  // Control FSM; rom_req and running are updated together with the state
  // they describe so both stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_HALT;
      cycle   <= CYC_CLEAR;
      pc      <= RESET_PC;
      ir      <= 8'h00;
      rom_req <= 1'b0;
      retire  <= 1'b0;
      running <= 1'b0;
      fault   <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_HALT: begin
          cycle   <= CYC_CLEAR;
          rom_req <= 1'b0;
          // A fault must be cleared on its own clock before anything starts.
          if (fault) begin
            if (clear_fault) begin
              fault <= 1'b0;
            end
          end else if (run) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (step) begin
            state   <= ST_STEP;
            running <= 1'b1;
          end
        end
        default: begin
          case (cycle)
            CYC_CLEAR: begin
              cycle   <= CYC_FETCH;
              rom_req <= 1'b1;
            end
            CYC_FETCH: begin
              cycle <= CYC_WAIT;
            end
            CYC_WAIT: begin
              if (rom_ack) begin
                ir      <= rom_data;
                cycle   <= CYC_DECODE;
                rom_req <= 1'b0;
              end else if (timed_out) begin
                fault   <= 1'b1;
                rom_req <= 1'b0;
                cycle   <= CYC_CLEAR;
                state   <= ST_HALT;
                running <= 1'b0;
              end
            end
            CYC_DECODE: begin
              cycle <= CYC_EXEC;
            end
            CYC_EXEC: begin
              cycle <= CYC_WB;
            end
            CYC_WB: begin
              pc     <= next_pc(jump, data, pc);
              retire <= 1'b1;
              cycle  <= CYC_CLEAR;
              if (!(state == ST_RUN && run)) begin
                state   <= ST_HALT;
                running <= 1'b0;
              end
            end
            default: begin
              cycle   <= CYC_CLEAR;
              rom_req <= 1'b0;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb04_sequencer.sv
// Self-checking bench for tb04_sequencer: directed instruction table,
// hand-written step/timeout/reset sequences, and a randomized run.
module tb_tb04_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       step;
  logic       clear_fault;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic       jump;
  logic [3:0] data;
  logic [2:0] cycle;
  logic [3:0] pc;
  logic       rom_req;
  logic [3:0] rom_addr;
  logic [3:0] command;
  logic [3:0] immediate;
  logic       wb_strobe;
  logic       retire;
  logic       running;
  logic       fault;

  tb04_sequencer #(
    .RESET_PC   (4'd0),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .clear_fault(clear_fault),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .jump       (jump),
    .data       (data),
    .cycle      (cycle),
    .pc         (pc),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .command    (command),
    .immediate  (immediate),
    .wb_strobe  (wb_strobe),
    .retire     (retire),
    .running    (running),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] rom [16];
  logic [3:0] m_pc;
  logic [7:0] m_ir;

  typedef struct {
    int unsigned dly;      // extra clocks before ack in cycle 3
    logic        jmp;
    logic [3:0]  tgt;
    logic        run_in;   // run level held through the instruction
    logic [3:0]  exp_pc;   // pc after writeback
    logic        exp_run;  // running after the instruction
  } instr_vec_t;

  instr_vec_t vecs [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected phase for clock k of an instruction whose ack comes d clocks late.
  function automatic logic [2:0] phase_at(input int unsigned k, input int unsigned d);
    if (k == 0) return 3'd1;
    if (k == 1) return 3'd2;
    if (k <= 2 + d) return 3'd3;
    if (k == 3 + d) return 3'd4;
    if (k == 4 + d) return 3'd5;
    return 3'd0;
  endfunction

  // Executes one instruction starting at its cycle-1 clock, acting as ROM and ALU.
  task automatic run_instr(input int unsigned d, input logic j, input logic [3:0] t,
                           input logic [3:0] exp_pc, input logic run_val,
                           input logic exp_run);
    logic [7:0] w;
    logic [2:0] ph;
    w = rom[m_pc];
    for (int unsigned k = 0; k < d + 6; k++) begin
      ph = phase_at(k, d);
      chk("cycle", {5'd0, cycle}, {5'd0, ph});
      chk("rom_req", {7'd0, rom_req}, {7'd0, (ph == 3'd2 || ph == 3'd3)});
      chk("rom_addr", {4'd0, rom_addr}, {4'd0, m_pc});
      chk("pc_hold", {4'd0, pc}, {4'd0, m_pc});
      chk("wb_strobe", {7'd0, wb_strobe}, {7'd0, (ph == 3'd0)});
      chk("running_in", {7'd0, running}, 8'd1);
      chk("fault_in", {7'd0, fault}, 8'd0);
      if (k > 0) chk("retire_mid", {7'd0, retire}, 8'd0);
      if (k >= 3 + d) chk("ir", {command, immediate}, w);
      run         = run_val;
      step        = 1'($urandom);
      clear_fault = 1'($urandom);
      if (k == 2 + d) begin
        rom_ack  = 1'b1;
        rom_data = w;
      end else begin
        // Stray acks outside cycle 3 must not be captured.
        rom_ack  = (ph != 3'd3) && ($urandom_range(0, 3) == 0);
        rom_data = 8'($urandom);
      end
      jump = (ph == 3'd0) ? j : 1'($urandom);
      data = (ph == 3'd0) ? t : 4'($urandom);
      tick();
    end
    rom_ack = 1'b0; step = 1'b0; clear_fault = 1'b0;
    m_pc = exp_pc;
    m_ir = w;
    chk("cycle_after", {5'd0, cycle}, 8'd1);
    chk("retire", {7'd0, retire}, 8'd1);
    chk("pc_next", {4'd0, pc}, {4'd0, exp_pc});
    chk("running_after", {7'd0, running}, {7'd0, exp_run});
    chk("rom_req_after", {7'd0, rom_req}, 8'd0);
  endtask

  initial begin
    logic [3:0] p;
    logic       jj;
    logic [3:0] tt;

    vecs[0] = '{0,  1'b0, 4'h0, 1'b1, 4'h1, 1'b1};
    vecs[1] = '{0,  1'b0, 4'h0, 1'b1, 4'h2, 1'b1};
    vecs[2] = '{2,  1'b0, 4'h0, 1'b1, 4'h3, 1'b1};
    vecs[3] = '{0,  1'b1, 4'hA, 1'b1, 4'hA, 1'b1};
    vecs[4] = '{3,  1'b0, 4'h0, 1'b1, 4'hB, 1'b1};
    vecs[5] = '{14, 1'b1, 4'h3, 1'b1, 4'h3, 1'b1};
    vecs[6] = '{0,  1'b0, 4'h0, 1'b1, 4'h4, 1'b1};
    vecs[7] = '{1,  1'b1, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[8] = '{0,  1'b0, 4'h0, 1'b1, 4'h0, 1'b1};
    vecs[9] = '{2,  1'b0, 4'h0, 1'b0, 4'h1, 1'b0};

    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);

    reset = 1'b1; run = 1'b0; step = 1'b0; clear_fault = 1'b0;
    rom_ack = 1'b0; rom_data = 8'h00; jump = 1'b0; data = 4'h0;
    m_pc = 4'd0; m_ir = 8'h00;
    tick(); tick();
    chk("rst_cycle", {5'd0, cycle}, 8'd1);
    chk("rst_pc", {4'd0, pc}, 8'd0);
    chk("rst_ir", {command, immediate}, 8'h00);
    chk("rst_rom_req", {7'd0, rom_req}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_fault", {7'd0, fault}, 8'd0);
    chk("rst_retire", {7'd0, retire}, 8'd0);
    chk("rst_wb_strobe", {7'd0, wb_strobe}, 8'd0);
    reset = 1'b0;
    tick();
    chk("halt_cycle", {5'd0, cycle}, 8'd1);
    chk("halt_running", {7'd0, running}, 8'd0);

    // Directed instruction table in RUN mode.
    run = 1'b1;
    tick();
    chk("start_running", {7'd0, running}, 8'd1);
    for (int i = 0; i < 10; i++)
      run_instr(vecs[i].dly, vecs[i].jmp, vecs[i].tgt, vecs[i].exp_pc,
                vecs[i].run_in, vecs[i].exp_run);

    // Halted: cycle and pc hold.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_hold_cycle", {5'd0, cycle}, 8'd1);
      chk("halt_hold_pc", {4'd0, pc}, {4'd0, m_pc});
      chk("halt_hold_req", {7'd0, rom_req}, 8'd0);
    end

    // Single step: exactly one instruction, then back to HALT.
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_running", {7'd0, running}, 8'd1);
    run_instr(0, 1'b0, 4'h0, 4'(m_pc + 4'd1), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("step_done_retire", {7'd0, retire}, 8'd0);
      chk("step_done_cycle", {5'd0, cycle}, 8'd1);
      chk("step_done_running", {7'd0, running}, 8'd0);
    end

    // run and step together: run wins and keeps going past one instruction.
    run = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    run_instr(1, 1'b0, 4'h0, 4'(m_pc + 4'd1), 1'b1, 1'b1);
    run_instr(0, 1'b0, 4'h0, 4'(m_pc + 4'd1), 1'b0, 1'b0);

    // ROM never acks: fault after 15 clocks in cycle 3.
    p = m_pc;
    run = 1'b1;
    tick();
    for (int unsigned k = 0; k < 17; k++) begin
      chk("to_cycle", {5'd0, cycle}, {5'd0, (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd3});
      chk("to_fault_early", {7'd0, fault}, 8'd0);
      chk("to_rom_req", {7'd0, rom_req}, {7'd0, (k >= 1)});
      tick();
    end
    chk("to_fault", {7'd0, fault}, 8'd1);
    chk("to_halt_cycle", {5'd0, cycle}, 8'd1);
    chk("to_running", {7'd0, running}, 8'd0);
    chk("to_req_drop", {7'd0, rom_req}, 8'd0);
    chk("to_pc", {4'd0, pc}, {4'd0, p});
    chk("to_retire", {7'd0, retire}, 8'd0);
    chk("to_ir", {command, immediate}, m_ir);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fault_blocks_run", {7'd0, running}, 8'd0);
      chk("fault_sticky", {7'd0, fault}, 8'd1);
    end
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_fault", {7'd0, fault}, 8'd0);
    chk("clr_no_start", {7'd0, running}, 8'd0);
    tick();
    chk("resume_running", {7'd0, running}, 8'd1);
    run_instr(0, 1'b0, 4'h0, 4'(p + 4'd1), 1'b0, 1'b0);

    // Asynchronous reset landing in cycle 4.
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    rom_ack = 1'b1; rom_data = 8'h5C;
    tick();
    rom_ack = 1'b0;
    chk("pre_rst_cycle", {5'd0, cycle}, 8'd4);
    chk("pre_rst_ir", {command, immediate}, 8'h5C);
    #2 reset = 1'b1;
    #1;
    chk("arst_cycle", {5'd0, cycle}, 8'd1);
    chk("arst_pc", {4'd0, pc}, 8'd0);
    chk("arst_rom_req", {7'd0, rom_req}, 8'd0);
    chk("arst_running", {7'd0, running}, 8'd0);
    chk("arst_ir", {command, immediate}, 8'h00);
    tick();
    reset = 1'b0;
    m_pc = 4'd0; m_ir = 8'h00;
    tick();

    // Randomized free run against the instruction-level model.
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    run = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      jj = 1'($urandom);
      tt = 4'($urandom);
      run_instr($urandom_range(0, 5), jj, tt, jj ? tt : 4'(m_pc + 4'd1),
                (i != 39), (i != 39));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tb04_sequencer.md
Name: tb04_sequencer

Overview:
- Instruction sequencer for the miniTB04 4-bit CPU.
- Generates the 3-bit `cycle` phase consumed by the ALU, owns the program counter, fetches 8-bit instruction words from program ROM over a req/ack handshake, and presents `command`/`immediate` to the ALU.
- Applies ALU `jump`/`data` to the PC at writeback and provides run/step/halt control with a ROM-timeout fault.

Parameters:
- RESET_PC, 4'd0, PC value loaded on reset.
- ACK_TIMEOUT, 15, max clocks spent in cycle 3 without `rom_ack` before fault (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = free-run instructions
- step  in  1  single-clock pulse; execute one instruction while halted
- clear_fault  in  1  single-clock pulse; clears `fault`
- rom_ack  in  1  ROM data valid
- rom_data  in  8  instruction word, [7:4]=opcode, [3:0]=immediate
- jump  in  1  from ALU (registered)
- data  in  4  from ALU (jump target)
- cycle  out  3  phase to ALU: 1,2,3,4,5,0 repeating
- pc  out  4  program counter
- rom_req  out  1  fetch request
- rom_addr  out  4  = pc
- command  out  4  instruction register [7:4]
- immediate  out  4  instruction register [3:0]
- wb_strobe  out  1  register-file write qualifier, = (cycle==0)
- retire  out  1  one-clock pulse at end of each executed instruction
- running  out  1  1 while not in HALT
- fault  out  1  sticky ROM-timeout flag

Behaviour:
- Reset (async): cycle=1, pc=RESET_PC, IR=8'h00 (command=0, immediate=0), rom_req=0, retire=0, running=0, fault=0, timeout counter=0, state=HALT.
- FSM states: HALT, RUN, STEP.
  - HALT holds cycle=1 and pc.
  - HALT→RUN on run=1 && !fault; HALT→STEP on step=1 && run=0 && !fault. run has priority over step.
- Phase sequence, one clock each except cycle 3:
  - 1: clear; ALU drops its pulses.
  - 2: rom_req=1.
  - 3: rom_req=1; wait for rom_ack. On the edge where cycle==3 && rom_ack: IR<=rom_data, go to 4. rom_ack is ignored outside cycle 3.
  - 4: decode settle.
  - 5: ALU executes at this edge.
  - 0: ALU outputs valid; wb_strobe=1. At the cycle-0 edge, pc<=jump ? data : pc+1 (4-bit wrap, 15→0) and retire pulses high in the following clock.
- Minimum instruction period = 6 clocks (ack seen in the first clock of cycle 3).
- Leaving cycle 0:
  - RUN with run=1 → cycle 1, continue.
  - run=0 → cycle 1, HALT.
  - STEP → cycle 1, HALT.
- Dropping run mid-instruction completes the instruction through cycle 0, then halts.
- Timeout:
  - Counter increments each clock in cycle 3 without ack; cleared on leaving cycle 3.
  - When it reaches ACK_TIMEOUT: fault<=1, rom_req<=0, cycle<=1, state<=HALT, IR and pc unchanged, no retire.
- Fault:
  - fault blocks RUN/STEP entry.
  - clear_fault clears it only while in HALT; ignored otherwise.
  - If clear_fault and run arrive together, clear that clock and start on the next.
- step while RUN or STEP is ignored.
- rom_addr is stable for the whole request.

Decomposition:
- Shared package tb04_pkg:
  - Cycle phase constants CYC_CLEAR=1, CYC_FETCH=2, CYC_WAIT=3, CYC_DECODE=4, CYC_EXEC=5, CYC_WB=0.
  - FSM state encoding.
  - The opcode localparams also used by the ALU.
- One natural sub-module: tb04_fetch_timer (timeout counter with clear/terminal-count output).

Test Plan:
- Reset, run=1, ROM acks in the first clock of cycle 3, ROM all 8'h01 → cycle trace 1,2,3,4,5,0 repeating; pc 0,1,2…; retire every 6 clocks; pc 15→0 wrap.
- ROM ack delayed 3 clocks → cycle 3 held 4 clocks; rom_req high throughout; IR=rom_data captured on the ack edge only.
- Drive jump=1, data=4'hA during cycle 0 at pc=3 → pc=A next; with jump=0 → pc=4.
- Halted, step pulse → exactly one instruction (one retire); returns to HALT with cycle=1; step during RUN has no effect.
- rom_ack never asserted, ACK_TIMEOUT=15 → fault=1 after 15 clocks in cycle 3; HALT; pc unchanged; run ignored until clear_fault, then resumes fetching same pc.
- Assert reset during cycle 4 → immediately cycle=1, pc=RESET_PC, rom_req=0, running=0, IR=0.
